// File: rtl/riscv_mini_pkg.sv
// Shared widths, fetch FSM states and the fetch FIFO entry layout.
package riscv_mini_pkg;

    localparam int ADDR_W      = 16;
    localparam int INSTR_W     = 32;
    localparam int FETCH_DEPTH = 2;
    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO with no bypass: a push is visible at the head one cycle later.
// Flush empties it at the next edge, overriding push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic [WIDTH-1:0]               head_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, 2-entry queue to decode.
// Grant at N gives instr_valid_o at N+2; stalls the PC when the queue cannot take a reply.
module instr_fetch import riscv_mini_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i
);
    localparam int OCC_W = FETCH_CNT_W + 1;

    fetch_state_e           state_q;
    logic [ADDR_W-1:0]      req_pc_q;
    logic                   push, pop, granted, can_issue;
    logic                   fifo_full, fifo_empty;
    logic [FETCH_CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]       occ_after;
    fetch_entry_t           push_entry, head;

    assign push       = rst_n && (state_q == FETCH_WAIT) && imem_rvalid_i && !flush_i;
    assign pop        = instr_valid_o && instr_ready_i;
    assign occ_after  = {1'b0, fifo_count} + OCC_W'(push) - OCC_W'(pop);
    assign can_issue  = (state_q == FETCH_IDLE) || ((state_q == FETCH_WAIT) && imem_rvalid_i);

    // A new request only goes out if its reply is guaranteed a free slot.
    assign imem_req_o  = rst_n && !flush_i && can_issue && (occ_after < OCC_W'(FETCH_DEPTH));
    assign imem_addr_o = pc_i;
    assign granted     = imem_req_o && imem_gnt_i;
    assign stall_o     = !rst_n || (!granted && !flush_i);

    assign push_entry    = '{pc: req_pc_q, instr: imem_rdata_i};
    assign instr_valid_o = rst_n && !fifo_empty;
    assign instr_o       = rst_n ? head.instr : '0;
    assign instr_pc_o    = rst_n ? head.pc : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH_IDLE;
            req_pc_q <= '0;
        end else begin
            if (granted) req_pc_q <= pc_i;
            case (state_q)
                FETCH_IDLE: if (granted) state_q <= FETCH_WAIT;
                FETCH_WAIT: begin
                    if (flush_i)            state_q <= imem_rvalid_i ? FETCH_IDLE : FETCH_DROP;
                    else if (imem_rvalid_i) state_q <= granted ? FETCH_WAIT : FETCH_IDLE;
                end
                FETCH_DROP: if (imem_rvalid_i) state_q <= FETCH_IDLE;
                default:    state_q <= FETCH_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule
